alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised successor to the combinational ALU: a multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide are iterative, one bit per cycle.
- Uses a valid/busy/done handshake, so the EX stage stalls on o_busy and reads o_hi/o_lo for MFHI/MFLO.

Parameters:
- NB_DATA, 32, operand and HI/LO width; must be even and ≥ 4.
- N_BITS_CONTROL, 5, opcode width.

Ports:
- i_clock, in, 1, single clock; all state updates on the rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_valid, in, 1, operation request.
- i_opcode, in, N_BITS_CONTROL, operation select.
- i_data_a, in, NB_DATA, operand A (rs): multiplicand / dividend / MT source.
- i_data_b, in, NB_DATA, operand B (rt): multiplier / divisor.
- i_flush, in, 1, abort the in-flight operation.
- o_busy, out, 1, iterative operation in progress.
- o_done, out, 1, one-cycle pulse; HI/LO hold the new result.
- o_div_zero, out, 1, valid only while o_done=1; divisor was zero.
- o_hi, out, NB_DATA, HI register.
- o_lo, out, NB_DATA, LO register.

Behaviour:
- Reset (synchronous, i_reset=1 at an edge): state IDLE; o_busy=0, o_done=0, o_div_zero=0, o_hi=0, o_lo=0. Reset overrides every other input, including mid-operation.
- Opcodes: 00000 MULT, 00001 MULTU, 00010 DIV, 00011 DIVU, 00100 MTHI, 00101 MTLO. All other codes are ignored: no state change, no o_done.
- Acceptance: at an edge with i_valid=1 and state IDLE. i_valid while busy is ignored (no queue); the requester holds the request until o_busy=0.
- MTHI/MTLO: single-cycle, accepted only in IDLE. HI (resp. LO) is loaded with i_data_a at the accept edge; no busy, no o_done.
- States:
  - IDLE -> ITER on accept of a mul/div op. Operands are latched and converted to magnitudes when the op is signed; sign flags are stored; the counter is loaded with NB_DATA.
  - ITER: one shift-add (mul) or restoring subtract (div) step per cycle. The counter decrements; ITER -> FIX when the counter reaches 0 (NB_DATA cycles).
  - FIX -> IDLE: apply sign correction, write HI/LO, set o_done=1 for the next cycle.
- Latency: accept at edge 0 -> o_busy=1 in cycles 1..NB_DATA+1 -> o_done=1 with new HI/LO in cycle NB_DATA+1 exactly, for all mul/div ops.
- Back-to-back: a new op may be accepted in the cycle o_done=1.
- Multiply result: the 2·NB_DATA-bit product, with {HI,LO}=product. Signed: the product is negated when the operand signs differ.
- Divide result: LO=quotient, HI=remainder. Signed: the quotient is negated when the signs differ; the remainder takes the dividend's sign (truncating division).
- Divide by zero: full latency still applies; LO=all ones, HI=i_data_a as latched (signed or unsigned); o_div_zero=1 with o_done.
- Signed overflow, MIN / -1: LO=MIN, HI=0, no flag.
- i_flush: at any edge in ITER/FIX, return to IDLE; HI/LO unchanged; no o_done.
- Simultaneous events: reset dominates flush, which dominates accept. Flush in IDLE is a no-op.

Optional Feature:
- Macro ALU_MULDIV_MADD_EN.
- Defined: opcodes 00110 MADD and 00111 MADDU are added. Same latency as MULT; in FIX, {HI,LO} <= {HI,LO} + product, with 2·NB_DATA-bit wrap-around. The accumulator read is the HI/LO value at FIX time.
- Undefined: 00110/00111 are unknown opcodes and are ignored; there is no accumulate adder in the netlist.

Decomposition:
- Package alu_muldiv_pkg holds:
  - opcode localparams (OP_MULT … OP_MADDU);
  - state encoding (ST_IDLE, ST_ITER, ST_FIX);
  - counter width function clog2(NB_DATA+1).
- One sub-module is natural: muldiv_sign_fix, a combinational sign correction of product/quotient/remainder plus the MIN/-1 and divide-by-zero overrides.
- The iteration datapath stays in alu_muldiv.

Test Plan (NB_DATA=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF accepted at edge 0 -> o_busy cycles 1..33; o_done in cycle 33 with HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7 b=2 -> LO=3, HI=1.
- DIV a=5 b=0 -> o_div_zero=1 with o_done, LO=0xFFFFFFFF, HI=5. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0, o_div_zero=0.
- Start MULT, then:
  - i_valid DIVU at cycle 5 -> ignored, HI/LO match the MULT result;
  - i_reset at cycle 10 of a second MULT -> cycle 11 o_busy=0, HI=LO=0, no o_done;
  - i_flush mid-op -> HI/LO keep prior values.
- MTHI a=0x1234 in IDLE -> o_hi=0x1234 next cycle, o_done=0. MTLO while busy -> ignored. With ALU_MULDIV_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 -> HI=1, LO=0.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - opcodes, state encoding and counter sizing for alu_muldiv
package alu_muldiv_pkg;

    localparam logic [4:0] OP_MULT  = 5'b00000;
    localparam logic [4:0] OP_MULTU = 5'b00001;
    localparam logic [4:0] OP_DIV   = 5'b00010;
    localparam logic [4:0] OP_DIVU  = 5'b00011;
    localparam logic [4:0] OP_MTHI  = 5'b00100;
    localparam logic [4:0] OP_MTLO  = 5'b00101;
    localparam logic [4:0] OP_MADD  = 5'b00110;
    localparam logic [4:0] OP_MADDU = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Ceiling log2; sized with value = NB_DATA + 1 so the counter can hold NB_DATA
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_muldiv_sign_fix.sv
// rtl/alu_muldiv_sign_fix.sv - sign correction and special-case overrides for mul/div results
module muldiv_sign_fix
    import alu_muldiv_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               is_div,
    input  logic               is_signed,
    input  logic [NB_DATA-1:0] a_raw,
    input  logic [NB_DATA-1:0] b_raw,
    input  logic [NB_DATA-1:0] mag_hi,
    input  logic [NB_DATA-1:0] mag_lo,
    output logic [NB_DATA-1:0] res_hi,
    output logic [NB_DATA-1:0] res_lo,
    output logic               div_zero
);

    localparam logic [NB_DATA-1:0] MIN_VAL = {1'b1, {(NB_DATA-1){1'b0}}};

    logic                   neg_a;
    logic                   neg_b;
    logic [2*NB_DATA-1:0]   prod;
    logic [NB_DATA-1:0]     quo;
    logic [NB_DATA-1:0]     rem;

    assign neg_a    = is_signed & a_raw[NB_DATA-1];
    assign neg_b    = is_signed & b_raw[NB_DATA-1];
    assign div_zero = is_div && (b_raw == '0);

    // Restore signs on the unsigned magnitudes, then apply divide special cases
    always_comb begin
        prod = {mag_hi, mag_lo};
        if (neg_a ^ neg_b) begin
            prod = -prod;
        end
        quo = (neg_a ^ neg_b) ? -mag_lo : mag_lo;
        rem = neg_a ? -mag_hi : mag_hi;
        if (!is_div) begin
            res_hi = prod[2*NB_DATA-1:NB_DATA];
            res_lo = prod[NB_DATA-1:0];
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else if (is_signed && (a_raw == MIN_VAL) && (b_raw == '1)) begin
            res_hi = '0;
            res_lo = MIN_VAL;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative multiply/divide unit owning HI/LO; ALU_MULDIV_MADD_EN adds MADD/MADDU
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int N_BITS_CONTROL = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [N_BITS_CONTROL-1:0] i_opcode,
    input  logic [NB_DATA-1:0]        i_data_a,
    input  logic [NB_DATA-1:0]        i_data_b,
    input  logic                      i_flush,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_div_zero,
    output logic [NB_DATA-1:0]        o_hi,
    output logic [NB_DATA-1:0]        o_lo
);

    localparam int CNT_W = clog2(NB_DATA + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NB_DATA-1:0] acc_hi, acc_lo, opnd, a_raw, b_raw, hi_q, lo_q;
    logic               op_div, op_signed;
    logic               busy_q, done_q, dz_q;

    logic               dec_mul, dec_div, dec_signed, dec_mthi, dec_mtlo;
    logic [NB_DATA-1:0] a_mag, b_mag;
    logic [NB_DATA:0]   mul_sum, div_shift;
    logic [NB_DATA-1:0] div_sub, step_hi, step_lo;
    logic               div_ge;
    logic [NB_DATA-1:0] res_hi, res_lo, wr_hi, wr_lo;
    logic               fix_dz;
`ifdef ALU_MULDIV_MADD_EN
    logic               dec_madd, op_madd;
    logic [2*NB_DATA-1:0] madd_sum;
`endif

    // Opcode decode; unknown codes leave every flag low so the request is ignored
    always_comb begin
        dec_mul    = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
        dec_mthi   = 1'b0;
        dec_mtlo   = 1'b0;
`ifdef ALU_MULDIV_MADD_EN
        dec_madd   = 1'b0;
`endif
        case (i_opcode)
            N_BITS_CONTROL'(OP_MULT):  begin dec_mul = 1'b1; dec_signed = 1'b1; end
            N_BITS_CONTROL'(OP_MULTU): dec_mul = 1'b1;
            N_BITS_CONTROL'(OP_DIV):   begin dec_div = 1'b1; dec_signed = 1'b1; end
            N_BITS_CONTROL'(OP_DIVU):  dec_div = 1'b1;
            N_BITS_CONTROL'(OP_MTHI):  dec_mthi = 1'b1;
            N_BITS_CONTROL'(OP_MTLO):  dec_mtlo = 1'b1;
`ifdef ALU_MULDIV_MADD_EN
            N_BITS_CONTROL'(OP_MADD):  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_madd = 1'b1; end
            N_BITS_CONTROL'(OP_MADDU): begin dec_mul = 1'b1; dec_madd = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign a_mag = (dec_signed && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
    assign b_mag = (dec_signed && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;

    // Multiply: {acc_hi,acc_lo} holds partial product over the shifting multiplier.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[NB_DATA-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[NB_DATA-1:0] - opnd;

    // One shift-add or restoring-subtract step
    always_comb begin
        if (op_div) begin
            step_hi = div_ge ? div_sub : div_shift[NB_DATA-1:0];
            step_lo = {acc_lo[NB_DATA-2:0], div_ge};
        end else begin
            step_hi = mul_sum[NB_DATA:1];
            step_lo = {mul_sum[0], acc_lo[NB_DATA-1:1]};
        end
    end

    // The final step feeds sign correction directly so HI/LO commit on the last iteration edge
    muldiv_sign_fix #(.NB_DATA(NB_DATA)) u_sign_fix (
        .is_div    (op_div),
        .is_signed (op_signed),
        .a_raw     (a_raw),
        .b_raw     (b_raw),
        .mag_hi    (step_hi),
        .mag_lo    (step_lo),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .div_zero  (fix_dz)
    );

`ifdef ALU_MULDIV_MADD_EN
    assign madd_sum = {hi_q, lo_q} + {res_hi, res_lo};
    assign wr_hi    = op_madd ? madd_sum[2*NB_DATA-1:NB_DATA] : res_hi;
    assign wr_lo    = op_madd ? madd_sum[NB_DATA-1:0] : res_lo;
`else
    assign wr_hi    = res_hi;
    assign wr_lo    = res_lo;
`endif

    // Sequencer: accept, iterate, commit HI/LO and pulse done; FIX is the done cycle and
    // already accepts the next request
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            a_raw     <= '0;
            b_raw     <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
            op_madd   <= 1'b0;
`endif
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                ST_ITER: begin
                    if (i_flush) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            hi_q   <= wr_hi;
                            lo_q   <= wr_lo;
                            done_q <= 1'b1;
                            dz_q   <= fix_dz;
                            state  <= ST_FIX;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    if (i_valid && !((state == ST_FIX) && i_flush)) begin
                        if (dec_mul || dec_div) begin
                            state     <= ST_ITER;
                            busy_q    <= 1'b1;
                            cnt       <= CNT_W'(NB_DATA);
                            a_raw     <= i_data_a;
                            b_raw     <= i_data_b;
                            op_div    <= dec_div;
                            op_signed <= dec_signed;
`ifdef ALU_MULDIV_MADD_EN
                            op_madd   <= dec_madd;
`endif
                            acc_hi    <= '0;
                            acc_lo    <= dec_div ? a_mag : b_mag;
                            opnd      <= dec_div ? b_mag : a_mag;
                        end else if (dec_mthi) begin
                            hi_q <= i_data_a;
                        end else if (dec_mtlo) begin
                            lo_q <= i_data_a;
                        end
                    end
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_div_zero = dz_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv with arithmetic reference model
module tb_alu_muldiv;

    localparam int NB = 32;
    localparam logic [4:0] OP_MULT  = 5'b00000;
    localparam logic [4:0] OP_MULTU = 5'b00001;
    localparam logic [4:0] OP_DIV   = 5'b00010;
    localparam logic [4:0] OP_DIVU  = 5'b00011;
    localparam logic [4:0] OP_MTHI  = 5'b00100;
    localparam logic [4:0] OP_MTLO  = 5'b00101;
    localparam logic [4:0] OP_MADD  = 5'b00110;
    localparam logic [4:0] OP_MADDU = 5'b00111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  opcode = 5'b0;
    logic [31:0] da = '0;
    logic [31:0] db = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.NB_DATA(NB), .N_BITS_CONTROL(5)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_valid    (valid),
        .i_opcode   (opcode),
        .i_data_a   (da),
        .i_data_b   (db),
        .i_flush    (flush),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (dz),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, returned as {div_zero, hi, lo}
    function automatic logic [64:0] model_result(input logic [4:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] h,
                                                 input logic [31:0] l);
        logic [63:0] p;
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            OP_MULT, OP_MADD:   p = sa * sb;
            OP_MULTU, OP_MADDU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {1'b0, ur, uq};
            end
            default: ;
        endcase
        if (op == OP_MADD || op == OP_MADDU) return {1'b0, {h, l} + p};
        return {1'b0, p};
    endfunction

    // Reference model: an accepted mul/div completes NB edges later; MT ops apply at once
    int          m_rem = 0;
    logic [4:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0, m_on = 1'b0;

    always @(posedge clk) begin
        logic [64:0] r;
        bit in_flight;
        m_on = 1'b1;
        if (rst) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
        end else begin
            in_flight = (m_rem > 0) || m_done;
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_rem > 0) begin
                if (flush) begin
                    m_rem = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        r = model_result(m_op, m_a, m_b, m_hi, m_lo);
                        m_dz = r[64]; m_hi = r[63:32]; m_lo = r[31:0]; m_done = 1'b1;
                    end
                end
            end else if (valid && !(in_flight && flush)) begin
                case (opcode)
`ifdef ALU_MULDIV_MADD_EN
                    OP_MADD, OP_MADDU,
`endif
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        m_rem = NB; m_op = opcode; m_a = da; m_b = db;
                    end
                    OP_MTHI: m_hi = da;
                    OP_MTLO: m_lo = da;
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_on) begin
            check("busy", busy, ((m_rem > 0) || m_done));
            check("done", done, m_done);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (m_done) check("div_zero", dz, m_dz);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; opcode = op; da = a; db = b;
        tick();
        valid = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; cycles counts from the accept edge
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) check("done_within_40", done, 1'b1);
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int c;
        issue(op, a, b);
        wait_done(c);
        check({name, "_latency"}, c, 33);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", dz, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst = 1'b0;
        tick();

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        run_op("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        tick();
        run_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        check("div_zero_flag", dz, 1'b1);
        tick();
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        check("div_ovf_flag", dz, 1'b0);

        // Request while busy is dropped
        tick();
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (4) tick();
        issue(OP_DIVU, 32'd100, 32'd3);
        wait_done(c);
        check("ignored_hi", hi, 32'd0);
        check("ignored_lo", lo, 32'd42);

        // Back-to-back accepts in the done cycle
        run_op("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("b2b_multu", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

        // Flush mid-operation
        tick();
        issue(OP_MULT, 32'd2, 32'd3);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_hi", hi, 32'd1);
        check("flush_lo", lo, 32'd0);
        repeat (40) tick();

        // Reset in cycle 10 of an operation
        issue(OP_MULT, 32'd9, 32'd9);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);

        // MTHI in idle, MTLO while busy
        tick();
        issue(OP_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_done", done, 1'b0);
        check("mthi_busy", busy, 1'b0);
        issue(OP_MULTU, 32'd2, 32'd3);
        tick();
        issue(OP_MTLO, 32'hDEAD, 32'd0);
        check("mtlo_busy_lo", lo, 32'd0);
        wait_done(c);
        check("mtlo_busy_res", lo, 32'd6);

        // Unknown opcodes are ignored
        tick();
        issue(5'b01010, 32'h5555, 32'd1);
        check("unk_busy", busy, 1'b0);
        check("unk_lo", lo, 32'd6);
`ifndef ALU_MULDIV_MADD_EN
        issue(OP_MADDU, 32'd1, 32'd1);
        check("madd_off_busy", busy, 1'b0);
        check("madd_off_lo", lo, 32'd6);
`else
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0);
        tick();
        run_op("madd_neg", OP_MADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
`endif
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
